// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl: IF/ID/EX/MEM/WB sequencer for the shared-memory CPU core
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
    parameter logic [5:0] OP_LWRR = 6'b110011,
    parameter int         CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             PCSrc,
    output logic             PCj,
    output logic             jr,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             jalsave,
    output logic             MemtoReg,
    output logic             LWRR,
    output logic             MemWrite,
    output logic             mem_req,
    output logic             ALUsrc,
    output logic             sign,
    output logic [2:0]       ALUControl,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NONE = 4'd0,
        C_ADDU = 4'd1,
        C_SUBU = 4'd2,
        C_JR   = 4'd3,
        C_ORI  = 4'd4,
        C_LUI  = 4'd5,
        C_LW   = 4'd6,
        C_SW   = 4'd7,
        C_BEQ  = 4'd8,
        C_JAL  = 4'd9,
        C_LWRR = 4'd10
    } class_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t cur_state, nxt_state;
    class_t cls, dec;
    logic   retire;
    logic   pc_wr, ir_wr, reg_wr, mem_wr, req;

    always_comb begin
        dec = C_NONE;
        case (op)
            6'b000000: begin
                case (func)
                    6'b100001: dec = C_ADDU;
                    6'b100011: dec = C_SUBU;
                    6'b001000: dec = C_JR;
                    default:   dec = C_NONE;
                endcase
            end
            6'b001101: dec = C_ORI;
            6'b001111: dec = C_LUI;
            6'b100011: dec = C_LW;
            6'b101011: dec = C_SW;
            6'b000100: dec = C_BEQ;
            6'b000011: dec = C_JAL;
            default:   dec = (op == OP_LWRR) ? C_LWRR : C_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= S_IF;
            cls       <= C_NONE;
            instret   <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_ID)
                cls <= dec;
            if (retire)
                instret <= instret + CNT_ONE;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        retire     = 1'b0;
        pc_wr      = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        req        = 1'b0;
        PCSrc      = 1'b0;
        PCj        = 1'b0;
        jr         = 1'b0;
        RegDst     = 1'b0;
        jalsave    = 1'b0;
        MemtoReg   = 1'b0;
        LWRR       = 1'b0;
        ALUsrc     = 1'b0;
        sign       = 1'b0;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (cur_state)
            S_IF: begin
                req   = 1'b1;
                ir_wr = mem_ready;
                pc_wr = mem_ready;
                if (mem_ready)
                    nxt_state = S_ID;
            end
            S_ID: begin
                sign = 1'b1;
                if (dec == C_JAL) begin
                    nxt_state = S_WB;
                end else if (dec == C_NONE) begin
                    illegal   = 1'b1;
                    nxt_state = S_IF;
                end else begin
                    nxt_state = S_EX;
                end
            end
            S_EX: begin
                case (cls)
                    C_ADDU: nxt_state = S_WB;
                    C_SUBU: begin
                        ALUControl = ALU_SUB;
                        nxt_state  = S_WB;
                    end
                    C_ORI: begin
                        ALUControl = ALU_OR;
                        ALUsrc     = 1'b1;
                        nxt_state  = S_WB;
                    end
                    C_LUI: begin
                        ALUControl = ALU_LUI;
                        ALUsrc     = 1'b1;
                        nxt_state  = S_WB;
                    end
                    C_LW, C_SW, C_LWRR: begin
                        ALUsrc    = 1'b1;
                        sign      = 1'b1;
                        nxt_state = S_MEM;
                    end
                    C_BEQ: begin
                        ALUControl = ALU_SUB;
                        PCSrc      = 1'b1;
                        pc_wr      = zero;
                        sign       = 1'b1;
                        retire     = 1'b1;
                        nxt_state  = S_IF;
                    end
                    C_JR: begin
                        jr        = 1'b1;
                        pc_wr     = 1'b1;
                        retire    = 1'b1;
                        nxt_state = S_IF;
                    end
                    default: nxt_state = S_IF;
                endcase
            end
            S_MEM: begin
                req    = 1'b1;
                ALUsrc = 1'b1;
                mem_wr = (cls == C_SW) && mem_ready;
                if (mem_ready) begin
                    if (cls == C_SW) begin
                        retire    = 1'b1;
                        nxt_state = S_IF;
                    end else begin
                        nxt_state = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wr    = 1'b1;
                retire    = 1'b1;
                nxt_state = S_IF;
                case (cls)
                    C_ADDU, C_SUBU: RegDst = 1'b1;
                    C_ORI: begin
                        ALUsrc     = 1'b1;
                        ALUControl = ALU_OR;
                    end
                    C_LUI: begin
                        ALUsrc     = 1'b1;
                        ALUControl = ALU_LUI;
                    end
                    C_LW: MemtoReg = 1'b1;
                    C_LWRR: begin
                        // Address path stays live so the rotate amount is valid
                        MemtoReg = 1'b1;
                        LWRR     = 1'b1;
                        ALUsrc   = 1'b1;
                    end
                    C_JAL: begin
                        jalsave = 1'b1;
                        PCj     = 1'b1;
                        pc_wr   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: nxt_state = S_IF;
        endcase
    end

    // Reset abandons an in-flight instruction without touching PC, GRF or DM
    assign PCWrite  = pc_wr & reset;
    assign IRWrite  = ir_wr & reset;
    assign RegWrite = reg_wr & reset;
    assign MemWrite = mem_wr & reset;
    assign mem_req  = req & reset;
    assign state    = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl: directed scoreboard bench for multicycle_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op, func;
    logic             zero, mem_ready;
    logic             PCWrite, IRWrite, PCSrc, PCj, jr, RegWrite, RegDst, jalsave;
    logic             MemtoReg, LWRR, MemWrite, mem_req, ALUsrc, sign, illegal;
    logic [2:0]       ALUControl, state;
    logic [CNT_W-1:0] instret;

    multicycle_ctrl #(.OP_LWRR(6'b110011), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .PCSrc(PCSrc), .PCj(PCj), .jr(jr), .RegWrite(RegWrite),
        .RegDst(RegDst), .jalsave(jalsave), .MemtoReg(MemtoReg),
        .LWRR(LWRR), .MemWrite(MemWrite), .mem_req(mem_req),
        .ALUsrc(ALUsrc), .sign(sign), .ALUControl(ALUControl),
        .state(state), .instret(instret), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Output vector: {PCWrite..sign (14 flags), ALUControl, state, illegal}
    localparam logic [20:0] F_PCW   = 21'h1 << 20;
    localparam logic [20:0] F_IRW   = 21'h1 << 19;
    localparam logic [20:0] F_PCSRC = 21'h1 << 18;
    localparam logic [20:0] F_PCJ   = 21'h1 << 17;
    localparam logic [20:0] F_JR    = 21'h1 << 16;
    localparam logic [20:0] F_RW    = 21'h1 << 15;
    localparam logic [20:0] F_RD    = 21'h1 << 14;
    localparam logic [20:0] F_JS    = 21'h1 << 13;
    localparam logic [20:0] F_M2R   = 21'h1 << 12;
    localparam logic [20:0] F_LWRR  = 21'h1 << 11;
    localparam logic [20:0] F_MW    = 21'h1 << 10;
    localparam logic [20:0] F_MREQ  = 21'h1 << 9;
    localparam logic [20:0] F_ASRC  = 21'h1 << 8;
    localparam logic [20:0] F_SIGN  = 21'h1 << 7;
    localparam logic [20:0] F_ILL   = 21'h1;

    typedef struct {
        logic        rst;
        logic        mr;
        logic        z;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [20:0] exp;
        string       tag;
    } step_t;

    step_t     q[$];
    int        checks = 0;
    int        errors = 0;
    int        model_ret = 0;
    logic [5:0] cur_op, cur_fn;
    logic      cur_z;
    string     cur_tag;

    function automatic logic [20:0] ev(input logic [2:0] st, input logic [2:0] alu,
                                       input logic [20:0] flags);
        return flags | (21'(alu) << 4) | (21'(st) << 1);
    endfunction

    task automatic push(input logic rst_i, input logic mr_i, input logic [20:0] e);
        step_t s;
        s.rst = rst_i; s.mr = mr_i; s.z = cur_z; s.op = cur_op; s.fn = cur_fn;
        s.exp = e; s.tag = cur_tag;
        q.push_back(s);
    endtask

    task automatic instr(input string t, input logic [5:0] o, input logic [5:0] f,
                         input logic z, input int if_waits);
        cur_tag = t; cur_op = o; cur_fn = f; cur_z = z;
        for (int i = 0; i < if_waits; i++)
            push(1'b1, 1'b0, ev(3'd0, 3'd0, F_MREQ));
        push(1'b1, 1'b1, ev(3'd0, 3'd0, F_MREQ | F_IRW | F_PCW));
        push(1'b1, 1'b1, ev(3'd1, 3'd0, F_SIGN));
    endtask

    task automatic drain();
        step_t       s;
        logic [20:0] obs;
        while (q.size() > 0) begin
            s = q.pop_front();
            reset = s.rst; mem_ready = s.mr; zero = s.z; op = s.op; func = s.fn;
            #1;
            obs = {PCWrite, IRWrite, PCSrc, PCj, jr, RegWrite, RegDst, jalsave,
                   MemtoReg, LWRR, MemWrite, mem_req, ALUsrc, sign,
                   ALUControl, state, illegal};
            checks++;
            assert (obs === s.exp) else begin
                errors++;
                $error("FAIL %s outputs got=%h exp=%h", s.tag, obs, s.exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_ret(input string t);
        checks++;
        assert (instret === CNT_W'(model_ret)) else begin
            errors++;
            $error("FAIL %s instret got=%0d exp=%0d", t, instret, model_ret);
        end
    endtask

    initial begin
        reset = 1'b0; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset held low: IF with every enable forced off
        cur_tag = "reset"; cur_op = '0; cur_fn = '0; cur_z = 1'b0;
        push(1'b0, 1'b1, ev(3'd0, 3'd0, '0));
        drain(); chk_ret("reset");

        instr("addu", 6'b000000, 6'b100001, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd0, '0));
        push(1'b1, 1'b1, ev(3'd4, 3'd0, F_RW | F_RD));
        model_ret++; drain(); chk_ret("addu");

        instr("lw", 6'b100011, 6'b000000, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd0, F_ASRC | F_SIGN));
        for (int i = 0; i < 3; i++)
            push(1'b1, 1'b0, ev(3'd3, 3'd0, F_MREQ | F_ASRC));
        push(1'b1, 1'b1, ev(3'd3, 3'd0, F_MREQ | F_ASRC));
        push(1'b1, 1'b1, ev(3'd4, 3'd0, F_RW | F_M2R));
        model_ret++; drain(); chk_ret("lw");

        instr("beq_taken", 6'b000100, 6'b000000, 1'b1, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd1, F_PCSRC | F_SIGN | F_PCW));
        instr("beq_not", 6'b000100, 6'b000000, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd1, F_PCSRC | F_SIGN));
        model_ret += 2; drain(); chk_ret("beq");

        instr("jal", 6'b000011, 6'b000000, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd4, 3'd0, F_RW | F_JS | F_PCJ | F_PCW));
        instr("jr", 6'b000000, 6'b001000, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd0, F_JR | F_PCW));
        model_ret += 2; drain(); chk_ret("jal_jr");

        instr("lwrr", 6'b110011, 6'b000000, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd0, F_ASRC | F_SIGN));
        push(1'b1, 1'b1, ev(3'd3, 3'd0, F_MREQ | F_ASRC));
        push(1'b1, 1'b1, ev(3'd4, 3'd0, F_RW | F_M2R | F_LWRR | F_ASRC));
        model_ret++; drain(); chk_ret("lwrr");

        // Undecoded opcode: pulse in ID, straight back to IF, no retire
        cur_tag = "illegal"; cur_op = 6'b111110; cur_fn = '0; cur_z = 1'b0;
        push(1'b1, 1'b1, ev(3'd0, 3'd0, F_MREQ | F_IRW | F_PCW));
        push(1'b1, 1'b1, ev(3'd1, 3'd0, F_SIGN | F_ILL));
        drain(); chk_ret("illegal");

        instr("ori", 6'b001101, 6'b000000, 1'b0, 2);
        push(1'b1, 1'b1, ev(3'd2, 3'd2, F_ASRC));
        push(1'b1, 1'b1, ev(3'd4, 3'd2, F_RW | F_ASRC));
        instr("lui", 6'b001111, 6'b000000, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd3, F_ASRC));
        push(1'b1, 1'b1, ev(3'd4, 3'd3, F_RW | F_ASRC));
        instr("subu", 6'b000000, 6'b100011, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd1, '0));
        push(1'b1, 1'b1, ev(3'd4, 3'd0, F_RW | F_RD));
        instr("sw", 6'b101011, 6'b000000, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd0, F_ASRC | F_SIGN));
        push(1'b1, 1'b1, ev(3'd3, 3'd0, F_MREQ | F_ASRC | F_MW));
        model_ret += 4; drain(); chk_ret("ori_lui_subu_sw");

        // Reset during sw MEM: write suppressed, back to IF, counter cleared
        instr("sw_reset", 6'b101011, 6'b000000, 1'b0, 0);
        push(1'b1, 1'b1, ev(3'd2, 3'd0, F_ASRC | F_SIGN));
        push(1'b0, 1'b1, ev(3'd3, 3'd0, F_ASRC));
        push(1'b1, 1'b1, ev(3'd0, 3'd0, F_MREQ | F_IRW | F_PCW));
        model_ret = 0; drain(); chk_ret("sw_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
